// File: rtl/sinc_decimator_pkg.sv
// Shared types and width/saturation helpers for the parametrised sinc decimator.
package sinc_decimator_pkg;

  typedef enum logic {
    MODE_INCR = 1'b0,
    MODE_CONT = 1'b1
  } mode_e;

  function automatic int acc_width(input int order, input int osr_log2);
    return order * osr_log2 + 1;
  endfunction

  function automatic int frame_len(input int order, input int osr_log2);
    return (1 << osr_log2) + order;
  endfunction

  // Callers truncate the 64-bit result to their own output width.
  function automatic logic [63:0] sat_shift(input logic [63:0] x, input int shift,
                                            input int width);
    logic [63:0] shifted;
    logic [63:0] max_v;
    shifted = x >> shift;
    max_v   = (64'd1 << width) - 64'd1;
    return (shifted > max_v) ? max_v : shifted;
  endfunction

endpackage

// File: rtl/sinc_spi_tx.sv
// Serial readout: synchronises sclk/cs_n, snapshots the result on cs_n fall and shifts it out MSB first.
// Optional SINC_SERIAL_PARITY_EN appends an even-parity bit after the data bits.
module sinc_spi_tx #(
  parameter int DOUT_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic [DOUT_W-1:0] data_i,
  output logic              sdo_o
);

`ifdef SINC_SERIAL_PARITY_EN
  localparam int SR_W = DOUT_W + 1;
`else
  localparam int SR_W = DOUT_W;
`endif

  logic [1:0]      sclk_sync_q;
  logic [1:0]      cs_sync_q;
  logic            sclk_prev_q;
  logic            cs_prev_q;
  logic [SR_W-1:0] shift_q;
  logic [SR_W-1:0] shift_d;
  logic [SR_W-1:0] snapshot;
  logic            sdo_q;
  logic            sdo_d;
  logic            sclk_rise;
  logic            cs_fall;

`ifdef SINC_SERIAL_PARITY_EN
  assign snapshot = {data_i, ^data_i};
`else
  assign snapshot = data_i;
`endif

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign cs_fall   = ~cs_sync_q[1] & cs_prev_q;

  // Zeros shift in behind the payload, so trailing bits read as 0 without a bit counter.
  always_comb begin
    shift_d = shift_q;
    if (cs_fall) begin
      shift_d = snapshot;
    end else if (sclk_rise && !cs_sync_q[1]) begin
      shift_d = {shift_q[SR_W-2:0], 1'b0};
    end
    sdo_d = ~cs_sync_q[1] & shift_d[SR_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      shift_q     <= '0;
      sdo_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      cs_sync_q   <= {cs_sync_q[0], cs_n_i};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
      shift_q     <= shift_d;
      sdo_q       <= sdo_d;
    end
  end

  assign sdo_o = sdo_q;

endmodule

// File: rtl/sinc_decimator_param.sv
// sinc^ORDER decimator with incremental (integrate-and-dump) and continuous (CIC) modes plus serial readout.
// Build option SINC_SERIAL_PARITY_EN adds a parity bit to the serial stream (see sinc_spi_tx).
module sinc_decimator_param
  import sinc_decimator_pkg::*;
#(
  parameter int ORDER    = 3,
  parameter int OSR_LOG2 = 9,
  parameter int DOUT_W   = 12,
  parameter int SHIFT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              data_in,
  output logic [DOUT_W-1:0] data_out,
  output logic              new_data,
  output logic              busy,
  input  logic              sclk,
  input  logic              cs_n,
  output logic              serial_data_out
);

  localparam int ACC_W = acc_width(ORDER, OSR_LOG2);
  localparam int N     = 1 << OSR_LOG2;
  localparam int F     = frame_len(ORDER, OSR_LOG2);
  localparam int CNT_W = $clog2(F);

  localparam logic [CNT_W-1:0] CNT_N         = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST_INCR = CNT_W'(F - 1);
  localparam logic [CNT_W-1:0] CNT_LAST_CONT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [2:0]       SETTLE_DONE   = 3'(ORDER);

  logic [ACC_W-1:0]  int_q [ORDER];
  logic [ACC_W-1:0]  int_d [ORDER];
  logic [ACC_W-1:0]  dly_q [ORDER];
  logic [ACC_W-1:0]  dly_d [ORDER];
  logic [ACC_W-1:0]  stage;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        settle_q, settle_d;
  mode_e             mode_q, mode_d;
  logic [DOUT_W-1:0] dout_q, dout_d;
  logic              nd_q, nd_d;
  logic              busy_q;

  always_comb begin
    int_d    = int_q;
    dly_d    = dly_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    mode_d   = mode_q;
    dout_d   = dout_q;
    nd_d     = 1'b0;
    stage    = '0;
    if (!en) begin
      for (int k = 0; k < ORDER; k++) begin
        int_d[k] = '0;
        dly_d[k] = '0;
      end
      cnt_d    = '0;
      settle_d = '0;
      mode_d   = mode_e'(mode);
    end else if (mode_q == MODE_INCR) begin
      if (cnt_q == CNT_LAST_INCR) begin
        dout_d = DOUT_W'(sat_shift(64'(int_q[ORDER-1]), SHIFT, DOUT_W));
        nd_d   = 1'b1;
        for (int k = 0; k < ORDER; k++) begin
          int_d[k] = '0;
          dly_d[k] = '0;
        end
        cnt_d    = '0;
        settle_d = '0;
        mode_d   = mode_e'(mode);
      end else begin
        // After N samples the first integrator freezes while the upper stages flush.
        if (cnt_q < CNT_N) int_d[0] = int_q[0] + ACC_W'(data_in);
        for (int k = 1; k < ORDER; k++) int_d[k] = int_q[k] + int_q[k-1];
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      int_d[0] = int_q[0] + ACC_W'(data_in);
      for (int k = 1; k < ORDER; k++) int_d[k] = int_q[k] + int_q[k-1];
      if (cnt_q == CNT_LAST_CONT) begin
        cnt_d = '0;
        stage = int_q[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
          dly_d[k] = stage;
          stage    = stage - dly_q[k];
        end
        // The first ORDER comb outputs still see the zeroed delay line.
        if (settle_q == SETTLE_DONE) begin
          dout_d = DOUT_W'(sat_shift(64'(stage), SHIFT, DOUT_W));
          nd_d   = 1'b1;
        end else begin
          settle_d = settle_q + 3'd1;
        end
        if (mode_e'(mode) != mode_q) begin
          mode_d = mode_e'(mode);
          for (int k = 0; k < ORDER; k++) begin
            int_d[k] = '0;
            dly_d[k] = '0;
          end
          settle_d = '0;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) begin
        int_q[k] <= '0;
        dly_q[k] <= '0;
      end
      cnt_q    <= '0;
      settle_q <= '0;
      mode_q   <= mode_e'(mode);
      dout_q   <= '0;
      nd_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      int_q    <= int_d;
      dly_q    <= dly_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      mode_q   <= mode_d;
      dout_q   <= dout_d;
      nd_q     <= nd_d;
      busy_q   <= en;
    end
  end

  assign data_out = dout_q;
  assign new_data = nd_q;
  assign busy     = busy_q;

  sinc_spi_tx #(
    .DOUT_W(DOUT_W)
  ) u_spi_tx (
    .clk   (clk),
    .rst   (rst),
    .sclk_i(sclk),
    .cs_n_i(cs_n),
    .data_i(dout_q),
    .sdo_o (serial_data_out)
  );

endmodule

// File: tb/tb_sinc_decimator_param.sv
// Scoreboard bench for sinc_decimator_param at default parameters; honours SINC_SERIAL_PARITY_EN.
module tb_sinc_decimator_param;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic        dataIn;
  logic [11:0] dataOut;
  logic        newData;
  logic        busy;
  logic        sclk;
  logic        csN;
  logic        serialOut;

  int checks     = 0;
  int errors     = 0;
  int cycleCount = 0;

  typedef struct {
    logic [11:0] value;
    int          cycle;
  } expect_t;

  expect_t expQ[$];

  sinc_decimator_param dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .mode           (mode),
    .data_in        (dataIn),
    .data_out       (dataOut),
    .new_data       (newData),
    .busy           (busy),
    .sclk           (sclk),
    .cs_n           (csN),
    .serial_data_out(serialOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Every new_data pulse must match the oldest expected (value, cycle) pair.
  always @(negedge clk) begin
    if (newData) begin
      checks = checks + 1;
      if (expQ.size() == 0) begin
        errors = errors + 1;
        $display("[TB] FAIL unexpected_pulse: got data_out=%0d at cycle %0d, expected no pulse",
                 dataOut, cycleCount);
      end else begin
        expect_t e;
        e = expQ.pop_front();
        if (dataOut !== e.value || cycleCount != e.cycle) begin
          errors = errors + 1;
          $display("[TB] FAIL pulse: got data_out=%0d at cycle %0d, expected %0d at cycle %0d",
                   dataOut, cycleCount, e.value, e.cycle);
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic enV, input logic modeV, input logic dataV);
    en     = enV;
    mode   = modeV;
    dataIn = dataV;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic expectPulse(input logic [11:0] value, input int cycle);
    expect_t e;
    e.value = value;
    e.cycle = cycle;
    expQ.push_back(e);
  endtask

  task automatic serialRead(input logic [11:0] word);
    logic [13:0] expBits;
`ifdef SINC_SERIAL_PARITY_EN
    expBits = {word, ^word, 1'b0};
`else
    expBits = {word, 2'b00};
`endif
    csN = 1'b0;
    waitCycles(8);
    for (int i = 13; i >= 0; i--) begin
      checkOutput($sformatf("serial_bit%0d", 13 - i), {31'd0, serialOut}, {31'd0, expBits[i]});
      sclk = 1'b1;
      waitCycles(5);
      sclk = 1'b0;
      waitCycles(5);
    end
    csN = 1'b1;
    waitCycles(5);
    checkOutput("serial_idle", {31'd0, serialOut}, 32'd0);
  endtask

  initial begin
    int c0;
    rst  = 1'b1;
    sclk = 1'b0;
    csN  = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(3);
    rst = 1'b0;
    waitCycles(1);
    checkOutput("reset_data_out", {20'd0, dataOut}, 32'd0);
    checkOutput("reset_new_data", {31'd0, newData}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_serial", {31'd0, serialOut}, 32'd0);

    $display("[TB] incremental, all ones");
    c0 = cycleCount;
    applyStimulus(1'b1, 1'b0, 1'b1);
    expectPulse(12'd686, c0 + 515);
    expectPulse(12'd686, c0 + 1030);
    waitCycles(600);
    checkOutput("busy_running", {31'd0, busy}, 32'd1);
    waitCycles(435);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("incr_ones_drained", expQ.size(), 32'd0);

    $display("[TB] serial readout of 686");
    serialRead(12'd686);

    $display("[TB] en dropped mid-frame");
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitCycles(300);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(10);
    checkOutput("abort_hold", {20'd0, dataOut}, 32'd686);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    c0 = cycleCount;
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitCycles(1);
    dataIn = 1'b0;
    expectPulse(12'd4, c0 + 515);
    waitCycles(520);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("impulse_drained", expQ.size(), 32'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitCycles(200);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("midrst_data_out", {20'd0, dataOut}, 32'd0);
    checkOutput("midrst_new_data", {31'd0, newData}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_serial", {31'd0, serialOut}, 32'd0);
    waitCycles(2);
    rst = 1'b0;
    c0 = cycleCount;
    expectPulse(12'd686, c0 + 515);
    waitCycles(520);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("midrst_drained", expQ.size(), 32'd0);

    $display("[TB] incremental zeros with overlapping serial read");
    c0 = cycleCount;
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectPulse(12'd0, c0 + 515);
    expectPulse(12'd0, c0 + 1030);
    waitCycles(450);
    serialRead(12'd686);
    while (cycleCount < c0 + 1035) @(negedge clk);
    checkOutput("zeros_busy", {31'd0, busy}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("zeros_drained", expQ.size(), 32'd0);

    $display("[TB] continuous, constant ones");
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(2);
    c0 = cycleCount;
    applyStimulus(1'b1, 1'b1, 1'b1);
    expectPulse(12'd4095, c0 + 2048);
    expectPulse(12'd4095, c0 + 2560);
    waitCycles(2565);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(2);
    checkOutput("cont_ones_drained", expQ.size(), 32'd0);

    $display("[TB] continuous, alternating");
    c0 = cycleCount;
    applyStimulus(1'b1, 1'b1, 1'b1);
    expectPulse(12'd2048, c0 + 2048);
    expectPulse(12'd2048, c0 + 2560);
    for (int i = 0; i < 2565; i++) begin
      waitCycles(1);
      dataIn = ~dataIn;
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(2);
    checkOutput("cont_alt_drained", expQ.size(), 32'd0);
    checkOutput("cont_alt_hold", {20'd0, dataOut}, 32'd2048);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
